// File: rtl/fir_mac_multich.sv
// Multi-channel time-multiplexed FIR: one MAC per channel, one tap per clock,
// shared runtime-loadable coefficients, per-channel circular history.
//
// state  | meaning
// IDLE   | ready for a sample set; an accepted set is written at hist[c][wp]
// MAC    | one tap per cycle, k = 0 .. NTAPS-1, result registered on the last tap
// OUT_ST | valid_out high, write pointer advances
module fir_mac_multich #(
  parameter int NTAPS = 64,
  parameter int NCH   = 2,
  parameter int DW    = 16,
  parameter int CW    = 10,
  parameter int OW    = 26,
  parameter int SHIFT = 0,
  localparam int AB   = $clog2(NTAPS),
  localparam int AW   = DW + CW + AB
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sample_valid_in,
  input  logic [NCH*DW-1:0]   sample_in,
  output logic                ready_out,
  input  logic                coef_we_in,
  input  logic [AB-1:0]       coef_addr_in,
  input  logic [CW-1:0]       coef_data_in,
  output logic [NCH*OW-1:0]   signal_out,
  output logic                valid_out,
  output logic [NCH-1:0]      sat_out,
  output logic                overrun_out
);

  typedef enum logic [1:0] {IDLE, MAC, OUT_ST} state_t;

  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  state_t state, state_nxt;

  logic        [AB-1:0]       wp;
  logic        [AB-1:0]       k;
  logic        [AB-1:0]       rd_idx;
  logic signed [DW-1:0]       hist [NCH][NTAPS];
  logic signed [CW-1:0]       coef [NTAPS];
  logic signed [AW-1:0]       acc [NCH];
  logic signed [DW+CW-1:0]    prod [NCH];
  logic signed [AW-1:0]       acc_sum [NCH];
  logic signed [AW-1:0]       scaled [NCH];
  logic signed [OW-1:0]       sat_val [NCH];
  logic        [NCH-1:0]      sat_flag;
  logic                       accept;
  logic                       last_tap;

  assign ready_out = (state == IDLE);
  assign accept    = sample_valid_in && ready_out;
  assign last_tap  = (state == MAC) && (k == AB'(NTAPS - 1));
  // Power-of-two depth makes the modulo a plain wrap of the subtraction
  assign rd_idx    = wp - k;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_valid_in) state_nxt = MAC;
      MAC:     if (last_tap)        state_nxt = OUT_ST;
      OUT_ST:                       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sat_flag = '0;
    for (int c = 0; c < NCH; c++) begin
      prod[c]    = coef[k] * hist[c][rd_idx];
      acc_sum[c] = acc[c] + AW'(prod[c]);
      scaled[c]  = acc_sum[c] >>> SHIFT;
      sat_val[c] = scaled[c][OW-1:0];
      if (scaled[c] > OMAX) begin
        sat_val[c]  = OMAX[OW-1:0];
        sat_flag[c] = 1'b1;
      end else if (scaled[c] < OMIN) begin
        sat_val[c]  = OMIN[OW-1:0];
        sat_flag[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wp          <= '0;
      k           <= '0;
      signal_out  <= '0;
      sat_out     <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
      for (int t = 0; t < NTAPS; t++) coef[t] <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc[c] <= '0;
        for (int t = 0; t < NTAPS; t++) hist[c][t] <= '0;
      end
    end else begin
      valid_out   <= last_tap;
      overrun_out <= sample_valid_in && !ready_out;
      if (coef_we_in) coef[coef_addr_in] <= coef_data_in;
      if (accept) begin
        k <= '0;
        for (int c = 0; c < NCH; c++) begin
          hist[c][wp] <= sample_in[c*DW +: DW];
          acc[c]      <= '0;
        end
      end
      if (state == MAC) begin
        k <= k + 1'b1;
        for (int c = 0; c < NCH; c++) acc[c] <= acc_sum[c];
      end
      // Result is registered with the final tap so it is stable while OUT_ST pulses valid_out
      if (last_tap) begin
        sat_out <= sat_flag;
        for (int c = 0; c < NCH; c++) signal_out[c*OW +: OW] <= sat_val[c];
      end
      if (state == OUT_ST) wp <= wp + 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_mac_multich.sv
// Scoreboard bench for fir_mac_multich: directed samples push expected outputs,
// a monitor pops and compares on every valid_out pulse.
module tb_fir_mac_multich;

  localparam int NTAPS = 64;
  localparam int NCH   = 2;
  localparam int DW    = 16;
  localparam int CW    = 10;
  localparam int OW    = 26;
  localparam int AB    = 6;

  typedef struct {
    logic signed [OW-1:0] e0;
    logic signed [OW-1:0] e1;
    logic [1:0]           sat;
  } exp_t;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                sample_valid_in;
  logic [NCH*DW-1:0]   sample_in;
  logic                ready_out;
  logic                coef_we_in;
  logic [AB-1:0]       coef_addr_in;
  logic [CW-1:0]       coef_data_in;
  logic [NCH*OW-1:0]   signal_out;
  logic                valid_out;
  logic [NCH-1:0]      sat_out;
  logic                overrun_out;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  fir_mac_multich dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .sample_valid_in(sample_valid_in), .sample_in(sample_in), .ready_out(ready_out),
    .coef_we_in(coef_we_in), .coef_addr_in(coef_addr_in), .coef_data_in(coef_data_in),
    .signal_out(signal_out), .valid_out(valid_out), .sat_out(sat_out),
    .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Valid appears in the cycle that follows edge accept+NTAPS
  always @(negedge clk_in) begin
    if (rst_in) begin
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (sample_valid_in && ready_out) acc_q.push_back(cyc + 1);
      if (valid_out) begin
        chk("valid_pulse_width", prev_valid, 0);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: ch0=%0d with empty scoreboard", $signed(signal_out[OW-1:0]));
        end else begin
          mon_e = exp_q.pop_front();
          chk("ch0_out", $signed(signal_out[0 +: OW]), mon_e.e0);
          chk("ch1_out", $signed(signal_out[OW +: OW]), mon_e.e1);
          chk("sat_out", sat_out, mon_e.sat);
          if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), NTAPS);
        end
      end
      prev_valid = valid_out;
    end
  end

  task automatic exp_push(input longint e0, input longint e1, input logic [1:0] s);
    exp_t e;
    e.e0 = OW'(e0); e.e1 = OW'(e1); e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(posedge clk_in); #1;
    while (!ready_out && n < 200) begin @(posedge clk_in); #1; n++; end
    if (!ready_out) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: ready_out=%0d after %0d cycles", ready_out, n);
    end
  endtask

  task automatic send(input logic signed [DW-1:0] s0, input logic signed [DW-1:0] s1);
    wait_ready();
    sample_in = {s1, s0}; sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic coef_wr(input int a, input logic signed [CW-1:0] d);
    @(posedge clk_in); #1;
    coef_we_in = 1'b1; coef_addr_in = AB'(a); coef_data_in = d;
    @(posedge clk_in); #1;
    coef_we_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk_in); #1; n++; end
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1; rst_in = 1'b1;
    @(posedge clk_in); #1; rst_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint v;
    rst_in = 1'b1; sample_valid_in = 1'b0; sample_in = '0;
    coef_we_in = 1'b0; coef_addr_in = '0; coef_data_in = '0;
    #23;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_signal", signal_out, 0);
    chk("rst_sat", sat_out, 0);
    chk("rst_overrun", overrun_out, 0);
    @(posedge clk_in); #1; rst_in = 1'b0;

    // Passthrough
    coef_wr(0, 1);
    exp_push(1234, -77, 2'b00);
    send(1234, -77);
    drain();

    // Impulse on ch0 walks through coef[k]=k+1, then leaves the window
    do_reset();
    for (int t = 0; t < NTAPS; t++) coef_wr(t, CW'(t + 1));
    for (int j = 0; j <= NTAPS; j++) begin
      exp_push((j < NTAPS) ? j + 1 : 0, 0, 2'b00);
      send((j == 0) ? 16'sd1 : 16'sd0, 16'sd0);
    end
    drain();

    // Saturation: positive ramps past +max on the third sample, then negative
    do_reset();
    for (int t = 0; t < NTAPS; t++) coef_wr(t, 10'sd511);
    for (int i = 1; i <= NTAPS; i++) begin
      v = longint'(i) * 511 * 32767;
      if (v > 33554431) exp_push(33554431, 33554431, 2'b11);
      else              exp_push(v, v, 2'b00);
      send(16'sd32767, 16'sd32767);
    end
    drain();
    do_reset();
    for (int t = 0; t < NTAPS; t++) coef_wr(t, 10'sd511);
    for (int i = 1; i <= NTAPS; i++) begin
      v = longint'(i) * 511 * -32768;
      if (v < -33554432) exp_push(-33554432, -33554432, 2'b11);
      else               exp_push(v, v, 2'b00);
      send(-16'sd32768, -16'sd32768);
    end
    drain();

    // Overrun: extra sample while busy is dropped and flagged
    do_reset();
    coef_wr(0, 10'sd3);
    coef_wr(1, -10'sd2);
    exp_push(300, -15, 2'b00);
    send(16'sd100, -16'sd5);
    repeat (5) @(posedge clk_in);
    #1;
    chk("busy_ready", ready_out, 0);
    sample_in = {-16'sd9999, 16'sd9999}; sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    chk("overrun_pulse", overrun_out, 1);
    @(posedge clk_in); #1;
    chk("overrun_clear", overrun_out, 0);
    drain();
    exp_push(3*7 - 2*100, 3*20 - 2*(-5), 2'b00);
    send(16'sd7, 16'sd20);
    drain();

    // Reset mid-MAC discards the computation and clears coefficients
    do_reset();
    coef_wr(0, 10'sd1);
    exp_push(500, 8, 2'b00);
    send(16'sd500, 16'sd8);
    drain();
    send(16'sd77, 16'sd3);
    repeat (29) @(posedge clk_in);
    #3; rst_in = 1'b1;
    #1;
    chk("midmac_signal", signal_out, 0);
    chk("midmac_valid", valid_out, 0);
    chk("midmac_sat", sat_out, 0);
    chk("midmac_ready", ready_out, 1);
    @(posedge clk_in); #1; rst_in = 1'b0;
    exp_push(0, 0, 2'b00);
    send(16'sd42, 16'sd42);
    drain();

    // Wrap: one-tap delay over 130 ramp samples; first sample shares its cycle with the coef write
    do_reset();
    exp_push(0, 0, 2'b00);
    wait_ready();
    coef_we_in = 1'b1; coef_addr_in = AB'(1); coef_data_in = 10'sd1;
    sample_in = '0; sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    coef_we_in = 1'b0; sample_valid_in = 1'b0;
    for (int n = 1; n < 130; n++) begin
      exp_push(n - 1, -(n - 1), 2'b00);
      send(DW'(n), DW'(-n));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
